// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU opcodes, arbiter state and flag indices.
// Imported by the ALU arbiter and its round-robin grant helper.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Bit positions inside the {neg, overflow, zero} flag vector
   localparam int FLAG_ZERO = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_NEG  = 2;

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way grant select: a lone requester always wins, a tie goes to prio.
// Ports: valid[1:0] requests, prio favoured index, grant[1:0] one-hot.
module rr_grant2
   import cpu_types_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       prio,
   output logic [1:0] grant
);

   always_comb begin
      grant = valid;
      if (&valid) begin
         grant = prio ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: IDLE grants, EXEC runs
// the ALU, RESP holds the result until the owner takes it. Ports: CLK/RST,
// reqN_* request handshakes, respN_* response handshakes, alu_* to and
// from the shared ALU, grant_cntN statistics.
// Build option: ALU_ARB_STATS_EN enables saturating per-requester grant counters.
module alu_arbiter
   import cpu_types_pkg::*;
#(
   parameter bit RR_INIT = 1'b0
)
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  word_t       req0_a,
   input  word_t       req0_b,
   input  aluop_t      req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  word_t       req1_a,
   input  word_t       req1_b,
   input  aluop_t      req1_op,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output word_t       resp0_data,
   output logic [2:0]  resp0_flags,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output word_t       resp1_data,
   output logic [2:0]  resp1_flags,
   output word_t       alu_porta,
   output word_t       alu_portb,
   output aluop_t      alu_aluop,
   input  word_t       alu_out,
   input  logic        alu_neg,
   input  logic        alu_ovf,
   input  logic        alu_zero,
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1
);

   arb_state_t stateQ;
   logic       prioQ;
   logic       ownerQ;
   logic [1:0] grant;
   logic       accept;
   logic       respHs;
   logic [2:0] aluFlags;

   rr_grant2 uGrant (
      .valid ({req1_valid, req0_valid}),
      .prio  (prioQ),
      .grant (grant)
   );

   assign accept     = (stateQ == IDLE) && (|grant);
   assign req0_ready = accept & grant[0];
   assign req1_ready = accept & grant[1];

   // Response handshake of the current owner only
   assign respHs = ownerQ ? (resp1_valid & resp1_ready)
                          : (resp0_valid & resp0_ready);

   always_comb begin
      aluFlags = '0;
      aluFlags[FLAG_NEG]  = alu_neg;
      aluFlags[FLAG_OVF]  = alu_ovf;
      aluFlags[FLAG_ZERO] = alu_zero;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stateQ      <= IDLE;
         prioQ       <= RR_INIT;
         ownerQ      <= 1'b0;
         alu_porta   <= '0;
         alu_portb   <= '0;
         alu_aluop   <= ALU_ADD;
         resp0_valid <= 1'b0;
         resp0_data  <= '0;
         resp0_flags <= '0;
         resp1_valid <= 1'b0;
         resp1_data  <= '0;
         resp1_flags <= '0;
      end else begin
         unique case (stateQ)
            IDLE: begin
               if (accept) begin
                  ownerQ    <= grant[1];
                  alu_porta <= grant[1] ? req1_a  : req0_a;
                  alu_portb <= grant[1] ? req1_b  : req0_b;
                  alu_aluop <= grant[1] ? req1_op : req0_op;
                  stateQ    <= EXEC;
               end
            end
            EXEC: begin
               if (ownerQ) begin
                  resp1_data  <= alu_out;
                  resp1_flags <= aluFlags;
                  resp1_valid <= 1'b1;
               end else begin
                  resp0_data  <= alu_out;
                  resp0_flags <= aluFlags;
                  resp0_valid <= 1'b1;
               end
               stateQ <= RESP;
            end
            RESP: begin
               if (respHs) begin
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  prioQ       <= ~ownerQ;
                  stateQ      <= IDLE;
               end
            end
            default: stateQ <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt0Q;
   logic [15:0] cnt1Q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt0Q <= '0;
         cnt1Q <= '0;
      end else if (accept) begin
         if (grant[0] && (cnt0Q != 16'hFFFF)) begin
            cnt0Q <= cnt0Q + 16'd1;
         end
         if (grant[1] && (cnt1Q != 16'hFFFF)) begin
            cnt1Q <= cnt1Q + 16'd1;
         end
      end
   end

   assign grant_cnt0 = cnt0Q;
   assign grant_cnt1 = cnt1Q;
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif

endmodule
